// File: rtl/lab4_pkg.sv
// Shared types and constants for the RC4 key-scheduling datapath.
package lab4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    READ_I,
    WAIT_I,
    READ_J,
    WAIT_J,
    WRITE_I,
    WRITE_J,
    NEXT,
    DONE
  } ksa_state_t;

  localparam int S_MEM_DEPTH = 256;
  localparam int KEY_BYTES   = 3;

endpackage

// File: rtl/ksa_key_byte_sel.sv
// Picks the key byte for the current i mod 3 phase.
// Byte 0 is the most significant byte of the key.
module ksa_key_byte_sel
  import lab4_pkg::*;
#(
  parameter int KEY_WIDTH = 24
) (
  input  logic [KEY_WIDTH-1:0] i_key,
  input  logic [1:0]           i_sel,
  output logic [7:0]           o_byte
);

  always_comb begin
    o_byte = i_key[7:0];
    unique case (i_sel)
      2'd0:    o_byte = i_key[23:16];
      2'd1:    o_byte = i_key[15:8];
      default: o_byte = i_key[7:0];
    endcase
  end

endmodule

// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling engine: permutes the S-memory in place
// using j = j + S[i] + key[i mod 3] and a swap of S[i], S[j].
module ksa_shuffle
  import lab4_pkg::*;
#(
  parameter int KEY_WIDTH  = 24,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_WIDTH-1:0]  secret_key,
  input  logic [7:0]            q,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [7:0]            data,
  output logic                  written_enable,
  output logic                  busy,
  output logic                  finish
);

  ksa_state_t            r_state;
  ksa_state_t            w_next;
  logic [ADDR_WIDTH-1:0] r_i;
  logic [ADDR_WIDTH-1:0] r_j;
  logic [7:0]            r_si;
  logic [7:0]            r_sj;
  logic [1:0]            r_kc;
  logic [7:0]            w_kbyte;
  logic [ADDR_WIDTH-1:0] w_j_next;
  logic                  w_last;

  ksa_key_byte_sel #(
    .KEY_WIDTH(KEY_WIDTH)
  ) u_sel (
    .i_key  (secret_key),
    .i_sel  (r_kc),
    .o_byte (w_kbyte)
  );

  assign w_j_next = r_j + ADDR_WIDTH'(q)
                  + ADDR_WIDTH'(w_kbyte);
  assign w_last   = (r_i == '1);

  always_comb begin
    w_next         = r_state;
    address        = '0;
    data           = '0;
    written_enable = 1'b0;
    busy           = 1'b0;
    finish         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = READ_I;
      end
      READ_I: begin
        busy    = 1'b1;
        address = r_i;
        w_next  = WAIT_I;
      end
      WAIT_I: begin
        busy   = 1'b1;
        w_next = READ_J;
      end
      READ_J: begin
        busy    = 1'b1;
        address = r_j;
        w_next  = WAIT_J;
      end
      WAIT_J: begin
        busy   = 1'b1;
        w_next = WRITE_I;
      end
      WRITE_I: begin
        busy           = 1'b1;
        address        = r_i;
        data           = r_sj;
        written_enable = 1'b1;
        w_next         = WRITE_J;
      end
      // Issued last so S[i] survives when i == j.
      WRITE_J: begin
        busy           = 1'b1;
        address        = r_j;
        data           = r_si;
        written_enable = 1'b1;
        w_next         = NEXT;
      end
      NEXT: begin
        busy   = 1'b1;
        w_next = w_last ? DONE : READ_I;
      end
      DONE: begin
        finish = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_si    <= '0;
      r_sj    <= '0;
      r_kc    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_i  <= '0;
        r_j  <= '0;
        r_kc <= '0;
      end
      if (r_state == WAIT_I) begin
        r_si <= q;
        r_j  <= w_j_next;
      end
      if (r_state == WAIT_J) r_sj <= q;
      if (r_state == NEXT && !w_last) begin
        r_i  <= r_i + 1'b1;
        r_kc <= (r_kc == 2'd2) ? 2'd0 : r_kc + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_ksa_shuffle.sv
// Directed bench for ksa_shuffle with a behavioural S-memory
// and a reference RC4 key-schedule model.
module tb_ksa_shuffle;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [23:0] secret_key = '0;
  logic [7:0]  q;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        written_enable;
  logic        busy;
  logic        finish;

  always #5 clk = ~clk;

  ksa_shuffle dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .secret_key     (secret_key),
    .q              (q),
    .address        (address),
    .data           (data),
    .written_enable (written_enable),
    .busy           (busy),
    .finish         (finish)
  );

  logic [7:0] mem [256];
  logic [7:0] exp_s [256];
  logic [7:0] r_a = '0;
  assign q = mem[r_a];

  always @(posedge clk) begin
    if (written_enable) mem[address] = data;
    r_a <= address;
  end

  int tick = 0;
  int t0 = 0;
  always @(posedge clk) tick <= tick + 1;

  int         wr_c [$];
  logic [7:0] wr_a [$];
  logic [7:0] wr_d [$];
  int         fin_c [$];

  always @(negedge clk) begin
    if (written_enable) begin
      wr_c.push_back(tick - t0);
      wr_a.push_back(address);
      wr_d.push_back(data);
    end
    if (finish) fin_c.push_back(tick - t0);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic init_mem();
    for (int n = 0; n < 256; n++) mem[n] = n[7:0];
  endtask

  task automatic build_exp(input logic [23:0] k);
    logic [7:0] jj, t, kb;
    jj = 8'd0;
    for (int n = 0; n < 256; n++) exp_s[n] = n[7:0];
    for (int n = 0; n < 256; n++) begin
      kb = 8'(k >> (8 * (2 - (n % 3))));
      jj = jj + exp_s[n] + kb;
      t = exp_s[n];
      exp_s[n] = exp_s[jj];
      exp_s[jj] = t;
    end
  endtask

  task automatic cmp_mem(input string tag);
    int bad;
    bad = 0;
    for (int n = 0; n < 256; n++)
      if (mem[n] !== exp_s[n]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic go(input logic [23:0] k);
    @(negedge clk);
    secret_key = k;
    wr_c.delete();
    wr_a.delete();
    wr_d.delete();
    fin_c.delete();
    t0 = tick;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    do @(negedge clk); while (tick - t0 < c);
  endtask

  int n_pre;

  initial begin
    #3;
    chk("reset_outs",
        {address, data, written_enable, busy, finish}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_we", written_enable, 0);

    init_mem();
    build_exp(24'h010203);
    go(24'h010203);
    wait_cyc(1800);
    chk("k1_wr_cnt", wr_c.size(), 512);
    chk("k1_it0_w0", {wr_c[0], wr_a[0], wr_d[0]},
        {32'd5, 8'h00, 8'h01});
    chk("k1_it0_w1", {wr_c[1], wr_a[1], wr_d[1]},
        {32'd6, 8'h01, 8'h00});
    chk("k1_it1_w0", {wr_c[2], wr_a[2], wr_d[2]},
        {32'd12, 8'h01, 8'h03});
    chk("k1_it1_w1", {wr_c[3], wr_a[3], wr_d[3]},
        {32'd13, 8'h03, 8'h00});
    chk("k1_fin_n", fin_c.size(), 1);
    chk("k1_fin_c", fin_c[0], 1793);
    cmp_mem("k1_mem");

    init_mem();
    build_exp(24'h000000);
    go(24'h000000);
    wait_cyc(7);
    chk("k0_w0", {wr_c[0], wr_a[0], wr_d[0]},
        {32'd5, 8'h00, 8'h00});
    chk("k0_w1", {wr_c[1], wr_a[1], wr_d[1]},
        {32'd6, 8'h00, 8'h00});
    chk("k0_s0", mem[0], 8'h00);
    wait_cyc(1800);
    cmp_mem("k0_mem");

    init_mem();
    build_exp(24'h000249);
    go(24'h000249);
    wait_cyc(1);
    chk("k2_busy_c1", busy, 1);
    wait_cyc(10);
    start = 1'b1;
    wait_cyc(11);
    start = 1'b0;
    wait_cyc(900);
    start = 1'b1;
    wait_cyc(901);
    start = 1'b0;
    wait_cyc(1792);
    chk("k2_busy_c1792", busy, 1);
    wait_cyc(1793);
    chk("k2_fin_c1793", {finish, busy}, 2'b10);
    wait_cyc(1800);
    chk("k2_idle_after", busy, 0);
    chk("k2_fin_n", fin_c.size(), 1);
    chk("k2_fin_c", fin_c[0], 1793);
    chk("k2_wr_cnt", wr_c.size(), 512);
    cmp_mem("k2_mem");

    init_mem();
    go(24'h000249);
    wait_cyc(500);
    reset = 1'b0;
    #1;
    chk("rst_outs",
        {address, data, written_enable, busy, finish}, 0);
    n_pre = wr_c.size();
    chk("rst_pre_wr", n_pre, 142);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_wr", wr_c.size(), n_pre);
    chk("rst_idle", {busy, finish}, 0);

    init_mem();
    build_exp(24'h000249);
    go(24'h000249);
    wait_cyc(1800);
    chk("re_fin_n", fin_c.size(), 1);
    chk("re_fin_c", fin_c[0], 1793);
    chk("re_wr_cnt", wr_c.size(), 512);
    cmp_mem("re_mem");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/ksa_shuffle.md
# ksa_shuffle

Key-scheduling (shuffle) engine for the RC4 decryption datapath. It runs after `s_memory_init` has filled the 256×8 S-memory with S[i]=i. It reads that memory back and permutes it in place using a 24-bit secret key: for i=0..255, j=j+S[i]+key[i mod 3], then swap S[i],S[j]. It owns the S-memory port only between `start` and `finish`; the top level muxes the port between this block and the init block.

## Interface
Parameters:
- `KEY_WIDTH`, default 24: secret key width, fixed at 3 bytes.
- `ADDR_WIDTH`, default 8: S-memory address width (256 entries).

Ports:
- `clk`  in  1: system clock (CLOCK_50).
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin shuffle. Sampled only in IDLE.
- `secret_key`  in  24: key. Byte 0 = [23:16], byte 1 = [15:8], byte 2 = [7:0]. Held stable while busy.
- `q`  in  8: S-memory read data.
- `address`  out  8: S-memory address.
- `data`  out  8: S-memory write data.
- `written_enable`  out  1: S-memory write strobe.
- `busy`  out  1: high from start-accept until finish.
- `finish`  out  1: one-cycle pulse when the shuffle is complete.

## Operation
- S-memory read timing: the memory registers `address` at the clock edge. `q` is valid during the following cycle and is captured at the end of that cycle.
- Internal registers: `i` (8b), `j` (8b), `si` (8b), `sj` (8b), state.
- States and transitions:
  - IDLE: if `start`=1, set i=0, j=0, `busy`=1, go to READ_I.
  - READ_I: `address`=i; go to WAIT_I.
  - WAIT_I: at exit, si<=q and j<=j+q+keybyte(i mod 3) (mod 256); go to READ_J.
  - READ_J: `address`=j (the new j); go to WAIT_J.
  - WAIT_J: at exit, sj<=q; go to WRITE_I.
  - WRITE_I: `address`=i, `data`=sj, `written_enable`=1; go to WRITE_J.
  - WRITE_J: `address`=j, `data`=si, `written_enable`=1; go to NEXT.
  - NEXT: if i==255, go to DONE; else i<=i+1 and go to READ_I.
  - DONE: `finish`=1, `busy`=0 at exit; go to IDLE.
- Arithmetic: all sums are 8-bit and wrap modulo 256. `i mod 3` comes from a 2-bit counter (0,1,2,0…) that resets to 0 with i. It is not computed by division.
- i==j: both writes target the same address. WRITE_J's value (si) wins, so S[i] is unchanged. This is required and correct.
- `written_enable` is asserted only in WRITE_I and WRITE_J.
- `start` while busy: ignored.
- `start` held high through DONE: a new run starts on the IDLE cycle after DONE.
- `secret_key` changes while busy: undefined result, not checked.

## Timing
- Reset (async, active-low) takes every output to 0 immediately: `address`=0, `data`=0, `written_enable`=0, `busy`=0, `finish`=0. i, j, si, sj and the key counter go to 0; state goes to IDLE.
- Reset mid-operation: the shuffle aborts with no further writes. Memory contents are left partially permuted; the top must re-run init.
- Per iteration: 7 cycles (READ_I through NEXT).
- Latency: the start-accept edge is cycle 0. READ_I for i=0 is cycle 1. `finish` is high in cycle 1793 (256×7 + 1).
- `busy` is high in cycles 1–1792 and low in the DONE cycle.
- No back-pressure. The block assumes exclusive memory access while busy.

## Structure
- Shared package `lab4_pkg` holds:
  - the `ksa_state_t` enum (IDLE, READ_I, WAIT_I, READ_J, WAIT_J, WRITE_I, WRITE_J, NEXT, DONE);
  - `S_MEM_DEPTH`=256;
  - `KEY_BYTES`=3.
- One sub-module, `ksa_key_byte_sel`: combinational byte select from `secret_key` by the 2-bit key counter.
- All other logic is a single registered FSM plus a datapath.

## Test plan
- Reset during IDLE: all outputs are 0 with no clock edge needed. After release, IDLE holds until `start`.
- Identity memory, `secret_key`=24'h010203, first iteration:
  - `written_enable` cycles are addr 0 data 8'h01, then addr 1 data 8'h00.
  - j=1 after iteration 0.
  - Second iteration: j=1+0+02=3, writes addr 1 data 3, then addr 3 data 0.
- Identity memory, `secret_key`=0, i=0: j=0, so two writes to addr 0 with data 0. S[0] stays 0 (i==j case).
- Full run with key 24'h000249 against the behavioural RC4 KSA model:
  - all 256 words match;
  - `finish` pulses exactly once, in cycle 1793;
  - exactly 512 write strobes occur.
- `start` re-pulsed at cycles 10 and 900: no effect, and timing is unchanged.
- `reset` asserted at cycle 500: outputs go to 0 asynchronously, no writes follow, and the block returns to IDLE. A fresh init plus `start` then completes normally.
